// File: rtl/order_master.sv
// order_master
// Initiator side of the worker order interface. Host commands are queued in a
// small FIFO. Each command is issued to a single worker as an order. The master
// waits for the worker's busy flag to rise and then fall. It then reads the
// result word at order_back through a RAM read port and returns it to the host.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   cmd_valid/cmd_ready            host command handshake (ready = FIFO not full)
//   cmd_start/cmd_len/cmd_back     command fields
//   order_valid                    order request to the worker
//   order_start/order_len/order_back  order fields, change only in IDLE
//   order_busy                     worker busy
//   ram_rd_en/ram_rd_addr          RAM read strobe/address
//   ram_rd_data                    RAM read data, one cycle after ram_rd_en
//   res_valid/res_ready            result handshake to the host
//   res_data/res_err               result word, timeout flag (data 0 on error)
module order_master #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_start,
    input  logic [ADDR_WIDTH-1:0] cmd_len,
    input  logic [ADDR_WIDTH-1:0] cmd_back,
    output logic                  order_valid,
    output logic [ADDR_WIDTH-1:0] order_start,
    output logic [ADDR_WIDTH-1:0] order_len,
    output logic [ADDR_WIDTH-1:0] order_back,
    input  logic                  order_busy,
    output logic                  ram_rd_en,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DATA_WIDTH-1:0] res_data,
    output logic                  res_err
);

    localparam int PTR_W = (FIFO_DEPTH < 2) ? 1 : $clog2(FIFO_DEPTH);
    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam int CMD_W = 3 * ADDR_WIDTH;
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT1_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   DEPTH_C   = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        RUN   = 3'd2,
        READ  = 3'd3,
        DATA  = 3'd4,
        RESP  = 3'd5
    } state_t;

    // Command FIFO storage and bookkeeping
    logic [CMD_W-1:0]      fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_r, rd_ptr_r;
    logic [PTR_W:0]        count_r, count_next_s;
    logic                  cmd_ready_r;
    logic                  push_s, pop_s, empty_s;
    logic [CMD_W-1:0]      head_s;
    logic [ADDR_WIDTH-1:0] head_start_s, head_len_s, head_back_s;

    // FSM state, timeout counter and registered outputs with their next values
    state_t                state_r, state_next_s;
    logic [CNT_W-1:0]      cnt_r, cnt_next_s, cnt_inc_s;
    logic                  order_valid_r, order_valid_next_s;
    logic [ADDR_WIDTH-1:0] order_start_r, order_start_next_s;
    logic [ADDR_WIDTH-1:0] order_len_r, order_len_next_s;
    logic [ADDR_WIDTH-1:0] order_back_r, order_back_next_s;
    logic                  ram_rd_en_r, ram_rd_en_next_s;
    logic [ADDR_WIDTH-1:0] ram_rd_addr_r, ram_rd_addr_next_s;
    logic                  res_valid_r, res_valid_next_s;
    logic [DATA_WIDTH-1:0] res_data_r, res_data_next_s;
    logic                  res_err_r, res_err_next_s;

    assign push_s       = cmd_valid && cmd_ready_r;
    assign empty_s      = (count_r == {(PTR_W + 1){1'b0}});
    assign head_s       = fifo_mem_r[rd_ptr_r];
    assign head_start_s = head_s[CMD_W-1 -: ADDR_WIDTH];
    assign head_len_s   = head_s[2*ADDR_WIDTH-1 -: ADDR_WIDTH];
    assign head_back_s  = head_s[ADDR_WIDTH-1:0];
    // Saturating increment: the counter never wraps back below TIMEOUT
    assign cnt_inc_s    = (cnt_r == CNT_MAX) ? cnt_r : (cnt_r + CNT_ONE);

    assign cmd_ready   = cmd_ready_r;
    assign order_valid = order_valid_r;
    assign order_start = order_start_r;
    assign order_len   = order_len_r;
    assign order_back  = order_back_r;
    assign ram_rd_en   = ram_rd_en_r;
    assign ram_rd_addr = ram_rd_addr_r;
    assign res_valid   = res_valid_r;
    assign res_data    = res_data_r;
    assign res_err     = res_err_r;

    // FIFO occupancy next value; push and pop never both hit a full or empty queue
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT1_ONE;
            2'b01:   count_next_s = count_r - CNT1_ONE;
            default: count_next_s = count_r;
        endcase
    end

    // FIFO pointers, occupancy and registered ready flag
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            count_r     <= {(PTR_W + 1){1'b0}};
            cmd_ready_r <= 1'b1;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r     <= count_next_s;
            cmd_ready_r <= (count_next_s != DEPTH_C);
        end
    end

    // FIFO storage; contents are dropped on reset by clearing the pointers
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= {cmd_start, cmd_len, cmd_back};
        end
    end

    // Next-state and next-output logic of the order FSM
    always_comb begin
        state_next_s       = state_r;
        pop_s              = 1'b0;
        cnt_next_s         = cnt_r;
        order_valid_next_s = order_valid_r;
        order_start_next_s = order_start_r;
        order_len_next_s   = order_len_r;
        order_back_next_s  = order_back_r;
        ram_rd_en_next_s   = 1'b0;
        ram_rd_addr_next_s = ram_rd_addr_r;
        res_valid_next_s   = res_valid_r;
        res_data_next_s    = res_data_r;
        res_err_next_s     = res_err_r;
        case (state_r)
            IDLE: begin
                // A worker still busy from an earlier order blocks the next pop
                if (!empty_s && !order_busy) begin
                    pop_s              = 1'b1;
                    cnt_next_s         = {CNT_W{1'b0}};
                    order_start_next_s = head_start_s;
                    order_len_next_s   = head_len_s;
                    order_back_next_s  = head_back_s;
                    if (head_len_s == {ADDR_WIDTH{1'b0}}) begin
                        state_next_s     = RESP;
                        res_valid_next_s = 1'b1;
                        res_data_next_s  = {DATA_WIDTH{1'b0}};
                        res_err_next_s   = 1'b0;
                    end else begin
                        state_next_s       = ISSUE;
                        order_valid_next_s = 1'b1;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            ISSUE: begin
                if (order_busy) begin
                    state_next_s       = RUN;
                    order_valid_next_s = 1'b0;
                    cnt_next_s         = {CNT_W{1'b0}};
                end else if (cnt_inc_s >= TIMEOUT_C) begin
                    state_next_s       = RESP;
                    order_valid_next_s = 1'b0;
                    cnt_next_s         = cnt_inc_s;
                    res_valid_next_s   = 1'b1;
                    res_data_next_s    = {DATA_WIDTH{1'b0}};
                    res_err_next_s     = 1'b1;
                end else begin
                    cnt_next_s = cnt_inc_s;
                end
            end
            RUN: begin
                if (!order_busy) begin
                    state_next_s       = READ;
                    ram_rd_en_next_s   = 1'b1;
                    ram_rd_addr_next_s = order_back_r;
                end else begin
                    state_next_s = RUN;
                end
            end
            READ: begin
                state_next_s = DATA;
            end
            DATA: begin
                state_next_s     = RESP;
                res_valid_next_s = 1'b1;
                res_data_next_s  = ram_rd_data;
                res_err_next_s   = 1'b0;
            end
            RESP: begin
                if (res_ready) begin
                    state_next_s     = IDLE;
                    res_valid_next_s = 1'b0;
                end else begin
                    state_next_s = RESP;
                end
            end
            default: begin
                state_next_s       = IDLE;
                order_valid_next_s = 1'b0;
                res_valid_next_s   = 1'b0;
            end
        endcase
    end

    // FSM state register and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            cnt_r         <= {CNT_W{1'b0}};
            order_valid_r <= 1'b0;
            order_start_r <= {ADDR_WIDTH{1'b0}};
            order_len_r   <= {ADDR_WIDTH{1'b0}};
            order_back_r  <= {ADDR_WIDTH{1'b0}};
            ram_rd_en_r   <= 1'b0;
            ram_rd_addr_r <= {ADDR_WIDTH{1'b0}};
            res_valid_r   <= 1'b0;
            res_data_r    <= {DATA_WIDTH{1'b0}};
            res_err_r     <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            cnt_r         <= cnt_next_s;
            order_valid_r <= order_valid_next_s;
            order_start_r <= order_start_next_s;
            order_len_r   <= order_len_next_s;
            order_back_r  <= order_back_next_s;
            ram_rd_en_r   <= ram_rd_en_next_s;
            ram_rd_addr_r <= ram_rd_addr_next_s;
            res_valid_r   <= res_valid_next_s;
            res_data_r    <= res_data_next_s;
            res_err_r     <= res_err_next_s;
        end
    end

endmodule

// File: tb/tb_order_master.sv
module tb_order_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_start, cmd_len, cmd_back;
    logic        order_valid;
    logic [15:0] order_start, order_len, order_back;
    logic        order_busy;
    logic        ram_rd_en;
    logic [15:0] ram_rd_addr;
    logic [15:0] ram_rd_data;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic        res_err;

    int n_cmp = 0;
    int n_bad = 0;

    // worker model controls
    bit worker_en   = 1'b0;
    int busy_cycles = 10;
    logic [15:0] ram [0:255];

    // monitor counters, sampled on the rising edge
    int cyc = 0, ov_rises = 0, ov_high = 0, ov_rise_cyc = 0, overlap = 0, field_chg = 0;
    int rd_en_cnt = 0, rd_en_cyc = 0, busy_fall_cyc = 0, rv_rises = 0, rv_rise_cyc = 0;
    logic [15:0] last_rd_addr = 16'd0;
    logic ov_prev = 1'b0, busy_prev = 1'b0, rv_prev = 1'b0;
    logic [15:0] ps_prev = 16'd0, pl_prev = 16'd0, pb_prev = 16'd0;

    order_master #(
        .ADDR_WIDTH(16), .DATA_WIDTH(16), .FIFO_DEPTH(4), .TIMEOUT(8)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_start(cmd_start), .cmd_len(cmd_len), .cmd_back(cmd_back),
        .order_valid(order_valid), .order_start(order_start),
        .order_len(order_len), .order_back(order_back), .order_busy(order_busy),
        .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_err(res_err)
    );

    always #5 clk = ~clk;

    // RAM read port, one cycle latency
    always @(posedge clk) begin
        if (ram_rd_en) ram_rd_data <= ram[ram_rd_addr[7:0]];
    end

    // longest strictly increasing run, the worker's job
    function automatic logic [15:0] lir(input logic [15:0] s, input logic [15:0] l);
        int best = 0;
        int run = 0;
        for (int i = 0; i < int'(l); i++) begin
            if (i == 0 || ram[(int'(s) + i) & 255] > ram[(int'(s) + i - 1) & 255]) run++;
            else run = 1;
            if (run > best) best = run;
        end
        return 16'(best);
    endfunction

    // worker model: sees order_valid, raises busy one cycle later, holds, writes result
    initial begin : worker
        logic [15:0] w_s, w_l, w_b;
        order_busy = 1'b0;
        for (int i = 0; i < 256; i++) ram[i] = 16'd0;
        ram[1] = 16'd1; ram[2] = 16'd3; ram[3] = 16'd5; ram[4] = 16'd4; ram[5] = 16'd7;
        ram[10] = 16'd2; ram[11] = 16'd4; ram[12] = 16'd6; ram[13] = 16'd8;
        ram[20] = 16'd5; ram[21] = 16'd5; ram[22] = 16'd5;
        ram[40] = 16'd1; ram[41] = 16'd2; ram[42] = 16'd3;
        ram[44] = 16'd7; ram[45] = 16'd1;
        forever begin
            @(posedge clk); #1;
            if (order_valid && worker_en) begin
                w_s = order_start; w_l = order_len; w_b = order_back;
                @(posedge clk); #1;
                order_busy = 1'b1;
                repeat (busy_cycles) @(posedge clk);
                #1;
                ram[w_b[7:0]] = lir(w_s, w_l);
                order_busy = 1'b0;
            end
        end
    end

    // protocol monitor
    always @(posedge clk) begin
        cyc       <= cyc + 1;
        ov_prev   <= order_valid;
        busy_prev <= order_busy;
        rv_prev   <= res_valid;
        ps_prev   <= order_start;
        pl_prev   <= order_len;
        pb_prev   <= order_back;
        if (order_valid && !ov_prev) begin
            ov_rises    <= ov_rises + 1;
            ov_rise_cyc <= cyc;
            if (order_busy) overlap <= overlap + 1;
        end
        if (order_valid) ov_high <= ov_high + 1;
        if (order_valid && ov_prev &&
            (order_start != ps_prev || order_len != pl_prev || order_back != pb_prev))
            field_chg <= field_chg + 1;
        if (ram_rd_en) begin
            rd_en_cnt    <= rd_en_cnt + 1;
            rd_en_cyc    <= cyc;
            last_rd_addr <= ram_rd_addr;
        end
        if (!order_busy && busy_prev) busy_fall_cyc <= cyc;
        if (res_valid && !rv_prev) begin
            rv_rises    <= rv_rises + 1;
            rv_rise_cyc <= cyc;
        end
    end

    task automatic push_cmd(input logic [15:0] s, input logic [15:0] l, input logic [15:0] b);
        cmd_start = s; cmd_len = l; cmd_back = b; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_res(output bit ok);
        int n = 0;
        while (!res_valid && n < 200) begin @(negedge clk); n++; end
        ok = res_valid;
    endtask

    task automatic wait_busy(output bit ok);
        int n = 0;
        while (!order_busy && n < 50) begin @(negedge clk); n++; end
        ok = order_busy;
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        n_cmp++; if (order_valid !== 1'b0) begin n_bad++; $display("FAIL %s order_valid got %0b want 0", tag, order_valid); end
        n_cmp++; if (order_start !== 16'd0) begin n_bad++; $display("FAIL %s order_start got %0d want 0", tag, order_start); end
        n_cmp++; if (order_len !== 16'd0) begin n_bad++; $display("FAIL %s order_len got %0d want 0", tag, order_len); end
        n_cmp++; if (order_back !== 16'd0) begin n_bad++; $display("FAIL %s order_back got %0d want 0", tag, order_back); end
        n_cmp++; if (ram_rd_en !== 1'b0) begin n_bad++; $display("FAIL %s ram_rd_en got %0b want 0", tag, ram_rd_en); end
        n_cmp++; if (ram_rd_addr !== 16'd0) begin n_bad++; $display("FAIL %s ram_rd_addr got %0d want 0", tag, ram_rd_addr); end
        n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL %s res_valid got %0b want 0", tag, res_valid); end
        n_cmp++; if (res_data !== 16'd0) begin n_bad++; $display("FAIL %s res_data got %0d want 0", tag, res_data); end
        n_cmp++; if (res_err !== 1'b0) begin n_bad++; $display("FAIL %s res_err got %0b want 0", tag, res_err); end
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL %s cmd_ready got %0b want 1", tag, cmd_ready); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        bit ok;
        int r0 = ov_rises, d0 = rd_en_cnt;
        worker_en = 1'b1; busy_cycles = 10;
        push_cmd(16'd1, 16'd5, 16'd0);
        n_cmp++; if (order_valid !== 1'b0) begin n_bad++; $display("FAIL single_ov_early got %0b want 0", order_valid); end
        @(negedge clk);
        n_cmp++; if (order_valid !== 1'b1) begin n_bad++; $display("FAIL single_ov_rise got %0b want 1", order_valid); end
        n_cmp++; if ({order_start, order_len, order_back} !== {16'd1, 16'd5, 16'd0}) begin n_bad++;
            $display("FAIL single_fields got %0d/%0d/%0d want 1/5/0", order_start, order_len, order_back); end
        wait_res(ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL single_res_wait got no res_valid want res_valid"); end
        @(negedge clk);
        n_cmp++; if (res_data !== 16'd3) begin n_bad++; $display("FAIL single_res_data got %0d want 3", res_data); end
        n_cmp++; if (res_err !== 1'b0) begin n_bad++; $display("FAIL single_res_err got %0b want 0", res_err); end
        n_cmp++; if (last_rd_addr !== 16'd0) begin n_bad++; $display("FAIL single_rd_addr got %0d want 0", last_rd_addr); end
        n_cmp++; if (rd_en_cnt - d0 !== 1) begin n_bad++; $display("FAIL single_rd_count got %0d want 1", rd_en_cnt - d0); end
        n_cmp++; if (ov_rises - r0 !== 1) begin n_bad++; $display("FAIL single_order_pulses got %0d want 1", ov_rises - r0); end
        n_cmp++; if (rd_en_cyc - busy_fall_cyc !== 1) begin n_bad++; $display("FAIL single_rd_lat got %0d want 1", rd_en_cyc - busy_fall_cyc); end
        n_cmp++; if (rv_rise_cyc - busy_fall_cyc !== 3) begin n_bad++; $display("FAIL single_res_lat got %0d want 3", rv_rise_cyc - busy_fall_cyc); end
        handshake();
        n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL single_res_drop got %0b want 0", res_valid); end
    endtask

    task automatic test_timeout();
        bit ok;
        int h0 = ov_high, d0 = rd_en_cnt;
        worker_en = 1'b0;
        push_cmd(16'd1, 16'd5, 16'd0);
        wait_res(ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL tmo_res_wait got no res_valid want res_valid"); end
        @(negedge clk);
        n_cmp++; if (ov_high - h0 !== 8) begin n_bad++; $display("FAIL tmo_ov_cycles got %0d want 8", ov_high - h0); end
        n_cmp++; if (rv_rise_cyc - ov_rise_cyc !== 8) begin n_bad++; $display("FAIL tmo_res_lat got %0d want 8", rv_rise_cyc - ov_rise_cyc); end
        n_cmp++; if (res_err !== 1'b1) begin n_bad++; $display("FAIL tmo_res_err got %0b want 1", res_err); end
        n_cmp++; if (res_data !== 16'd0) begin n_bad++; $display("FAIL tmo_res_data got %0d want 0", res_data); end
        n_cmp++; if (rd_en_cnt - d0 !== 0) begin n_bad++; $display("FAIL tmo_rd_count got %0d want 0", rd_en_cnt - d0); end
        handshake();
        worker_en = 1'b1; busy_cycles = 4;
        push_cmd(16'd10, 16'd4, 16'd33);
        wait_res(ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL tmo_next_wait got no res_valid want res_valid"); end
        n_cmp++; if ({res_err, res_data} !== {1'b0, 16'd4}) begin n_bad++; $display("FAIL tmo_next_res got err %0b data %0d want err 0 data 4", res_err, res_data); end
        n_cmp++; if (last_rd_addr !== 16'd33) begin n_bad++; $display("FAIL tmo_next_rd_addr got %0d want 33", last_rd_addr); end
        handshake();
    endtask

    task automatic test_zero_len();
        int r0 = ov_rises, d0 = rd_en_cnt;
        push_cmd(16'd2, 16'd0, 16'd9);
        n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL zero_res_early got %0b want 0", res_valid); end
        @(negedge clk);
        n_cmp++; if (res_valid !== 1'b1) begin n_bad++; $display("FAIL zero_res_valid got %0b want 1", res_valid); end
        n_cmp++; if ({res_err, res_data} !== {1'b0, 16'd0}) begin n_bad++; $display("FAIL zero_res got err %0b data %0d want err 0 data 0", res_err, res_data); end
        @(negedge clk);
        n_cmp++; if (ov_rises - r0 !== 0) begin n_bad++; $display("FAIL zero_no_order got %0d want 0", ov_rises - r0); end
        n_cmp++; if (rd_en_cnt - d0 !== 0) begin n_bad++; $display("FAIL zero_no_read got %0d want 0", rd_en_cnt - d0); end
        handshake();
    endtask

    task automatic test_backpressure();
        bit ok;
        worker_en = 1'b1; busy_cycles = 3; res_ready = 1'b0;
        push_cmd(16'd10, 16'd4, 16'd34);
        push_cmd(16'd20, 16'd3, 16'd35);
        wait_res(ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL bp_res_wait got no res_valid want res_valid"); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++; if ({res_valid, res_data} !== {1'b1, 16'd4}) begin n_bad++; $display("FAIL bp_hold got valid %0b data %0d want valid 1 data 4", res_valid, res_data); end
            n_cmp++; if (order_valid !== 1'b0) begin n_bad++; $display("FAIL bp_no_issue got %0b want 0", order_valid); end
        end
        handshake();
        n_cmp++; if ({res_valid, order_valid} !== 2'b00) begin n_bad++; $display("FAIL bp_after_hs got res_valid %0b order_valid %0b want 0 0", res_valid, order_valid); end
        @(negedge clk);
        n_cmp++; if ({order_valid, order_start} !== {1'b1, 16'd20}) begin n_bad++; $display("FAIL bp_next_issue got valid %0b start %0d want valid 1 start 20", order_valid, order_start); end
        wait_res(ok);
        n_cmp++; if (!ok || res_data !== 16'd1) begin n_bad++; $display("FAIL bp_second_res got %0d want 1", res_data); end
        handshake();
    endtask

    task automatic test_queue_fill();
        bit ok;
        int got = 0;
        int ov0 = overlap, fc0 = field_chg;
        logic [15:0] qs [4] = '{16'd20, 16'd10, 16'd1, 16'd44};
        logic [15:0] ql [4] = '{16'd3, 16'd4, 16'd5, 16'd2};
        logic [15:0] qb [4] = '{16'd37, 16'd38, 16'd39, 16'd40};
        logic [15:0] qexp [5] = '{16'd3, 16'd1, 16'd4, 16'd3, 16'd1};
        worker_en = 1'b1; busy_cycles = 20; res_ready = 1'b0;
        push_cmd(16'd40, 16'd3, 16'd36);
        wait_busy(ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL qf_busy_wait got busy 0 want 1"); end
        for (int i = 0; i < 4; i++) begin
            cmd_start = qs[i]; cmd_len = ql[i]; cmd_back = qb[i]; cmd_valid = 1'b1;
            @(negedge clk);
            if (i == 2) begin
                n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL qf_ready_3 got %0b want 1", cmd_ready); end
            end
        end
        cmd_valid = 1'b0;
        n_cmp++; if ({cmd_ready, order_busy} !== 2'b01) begin n_bad++; $display("FAIL qf_full got ready %0b busy %0b want 0 1", cmd_ready, order_busy); end
        res_ready = 1'b1;
        for (int c = 0; c < 600 && got < 5; c++) begin
            @(negedge clk);
            if (res_valid) begin
                n_cmp++; if (res_data !== qexp[got]) begin n_bad++; $display("FAIL qf_res%0d got %0d want %0d", got, res_data, qexp[got]); end
                got++;
            end
        end
        @(negedge clk);
        res_ready = 1'b0;
        n_cmp++; if (got !== 5) begin n_bad++; $display("FAIL qf_count got %0d want 5", got); end
        n_cmp++; if (overlap - ov0 !== 0) begin n_bad++; $display("FAIL qf_overlap got %0d want 0", overlap - ov0); end
        n_cmp++; if (field_chg - fc0 !== 0) begin n_bad++; $display("FAIL qf_field_change got %0d want 0", field_chg - fc0); end
    endtask

    task automatic test_reset_mid_run();
        bit ok;
        int r0, v0;
        worker_en = 1'b1; busy_cycles = 10; res_ready = 1'b0;
        push_cmd(16'd1, 16'd5, 16'd41);
        push_cmd(16'd10, 16'd4, 16'd42);
        wait_busy(ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL rmr_busy_wait got busy 0 want 1"); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("rmr");
        rst = 1'b0;
        r0 = ov_rises; v0 = rv_rises;
        repeat (30) @(negedge clk);
        n_cmp++; if (order_busy !== 1'b0) begin n_bad++; $display("FAIL rmr_worker_done got %0b want 0", order_busy); end
        n_cmp++; if (ov_rises - r0 !== 0) begin n_bad++; $display("FAIL rmr_no_order got %0d want 0", ov_rises - r0); end
        n_cmp++; if (rv_rises - v0 !== 0) begin n_bad++; $display("FAIL rmr_no_result got %0d want 0", rv_rises - v0); end
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_start = 16'd0; cmd_len = 16'd0; cmd_back = 16'd0;
        res_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_timeout();
        test_zero_len();
        test_backpressure();
        test_queue_fill();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
